sr_latch_bank_ctrl: RTL

//  Controller sharing a bank of NLAT gated SR latches (s, r, enable -> q, qn) between NREQ requesters.
//  - Arbitrates set/reset/read commands round-robin.
//  - Sequences the latch s/r/enable pins with setup, pulse and hold phases.
//  - Reads back q to verify each write.
//  - Blocks the forbidden s=r=1 combination from ever reaching a latch.

---
 rtl/sr_ctrl_pkg.sv | 30 +++
 rtl/sr_latch_bank_ctrl_if.sv | 34 +++
 rtl/sr_rr_arbiter.sv | 36 +++
 rtl/sr_latch_bank_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared encodings and helpers for the SR latch bank controllers.
// Command and FSM encodings live here so every bank controller decodes them identically.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_READ    = 2'b00,
        CMD_SET     = 2'b01,
        CMD_RESET   = 2'b10,
        CMD_ILLEGAL = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Accept-to-response latency: reads/errors answer next cycle, writes take WR_FIXED + pulse width.
    localparam int RESP_LAT_SHORT    = 1;
    localparam int RESP_LAT_WR_FIXED = 3;

    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/sr_latch_bank_ctrl_if.sv
// Requester command/response bus plus latch bank pins for the SR latch bank controller.
// The controller connects through the slave modport; the agents/bank side uses master.
interface sr_latch_bank_ctrl_if #(
    parameter int NREQ = 4,
    parameter int NLAT = 8,
    parameter int AW   = $clog2(NLAT)
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [2*NREQ-1:0]  req_cmd;
    logic [AW*NREQ-1:0] req_addr;

    logic               rsp_valid;
    logic [IW-1:0]      rsp_id;
    logic               rsp_q;
    logic               rsp_err;

    logic [NLAT-1:0]    lat_s;
    logic [NLAT-1:0]    lat_r;
    logic [NLAT-1:0]    lat_en;
    logic [NLAT-1:0]    lat_q;

    modport slave (
        input  req_valid, req_cmd, req_addr, lat_q,
        output req_ready, rsp_valid, rsp_id, rsp_q, rsp_err, lat_s, lat_r, lat_en
    );

    modport master (
        output req_valid, req_cmd, req_addr, lat_q,
        input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_err, lat_s, lat_r, lat_en
    );
endinterface

// File: rtl/sr_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr, first requester wins; no grant unless advance.
// The caller owns the pointer so it can decide when a grant actually commits.
module sr_rr_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            advance,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        if (advance) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = IW'(rr_wrap(32'(ptr), unsigned'(i), NREQ));
                if (!gnt_vld && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_idx  = idx;
                    gnt_vld  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// Shares one bank of gated SR latches between NREQ agents: round-robin accept, sequenced
// setup/pulse/hold write with read-back verify, single-cycle read; s and r never both high.
module sr_latch_bank_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int NLAT      = 8,
    parameter int AW        = $clog2(NLAT),
    parameter int PULSE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_latch_bank_ctrl_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic [NLAT-1:0] lat_sel(input logic [AW-1:0] a);
        return {{(NLAT-1){1'b0}}, 1'b1} << a;
    endfunction

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            is_set_q, is_set_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            qv_q, qv_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_vld;
    logic            arb_en;

    cmd_t            win_cmd;
    logic [AW-1:0]   win_addr;
    logic            win_addr_ok;
    logic            win_q;
    logic            cur_q;
    logic [NLAT-1:0] cur_sel;
    logic            wr_phase;
    logic            rsp_vld;

    // No grants while reset is held, so req_ready is 0 throughout reset.
    assign arb_en = (state_q == ST_IDLE) && rst_n;

    sr_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .advance (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign bus.req_ready = gnt;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        addr_d      = addr_q;
        is_set_d    = is_set_q;
        cnt_d       = cnt_q;
        qv_d        = qv_q;
        err_d       = err_q;
        win_cmd     = cmd_t'(bus.req_cmd[2*gnt_idx +: 2]);
        win_addr    = bus.req_addr[AW*gnt_idx +: AW];
        win_addr_ok = 32'(win_addr) < 32'(NLAT);
        win_q       = |(bus.lat_q & lat_sel(win_addr));
        cur_sel     = lat_sel(addr_q);
        cur_q       = |(bus.lat_q & cur_sel);

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    ptr_d    = IW'(rr_wrap(32'(gnt_idx), 1, NREQ));
                    id_d     = gnt_idx;
                    addr_d   = win_addr;
                    is_set_d = (win_cmd == CMD_SET);
                    if (win_addr_ok && (win_cmd == CMD_SET || win_cmd == CMD_RESET)) begin
                        state_d = ST_SETUP;
                        qv_d    = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_RESP;
                        qv_d    = (win_cmd == CMD_READ && win_addr_ok) ? win_q : 1'b0;
                        err_d   = !(win_cmd == CMD_READ && win_addr_ok);
                    end
                end
            end
            ST_SETUP: begin
                cnt_d   = 4'(PULSE_CYC - 1);
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                qv_d    = cur_q;
                err_d   = (cur_q != is_set_q);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pins decode from the registered state only; s and r come from one select, so they are exclusive.
    always_comb begin
        wr_phase      = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_HOLD);
        rsp_vld       = (state_q == ST_RESP);
        bus.lat_s     = (wr_phase &&  is_set_q) ? cur_sel : '0;
        bus.lat_r     = (wr_phase && !is_set_q) ? cur_sel : '0;
        bus.lat_en    = (state_q == ST_PULSE)   ? cur_sel : '0;
        bus.rsp_valid = rsp_vld;
        bus.rsp_id    = rsp_vld ? id_q : '0;
        bus.rsp_q     = rsp_vld & qv_q;
        bus.rsp_err   = rsp_vld & err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            is_set_q <= 1'b0;
            cnt_q    <= '0;
            qv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            is_set_q <= is_set_d;
            cnt_q    <= cnt_d;
            qv_q     <= qv_d;
            err_q    <= err_d;
        end
    end

endmodule
